// File: rtl/egg_timer_datapath.sv
// ----------------------------------------------------------------------------
// egg_timer_datapath
//
// Timekeeping datapath for the egg timer. Follows the 3-bit state code from
// the control FSM: loads MM:SS from the switches, counts down in BCD once per
// second in TIMER, raises a sticky time_up at 00:00, and in the flash states
// drives the alarm LED and produces the half-second pacing pulse.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   state      in   [2:0] controller state code
//   set_val    in   [7:0] BCD switch value, [7:4] tens, [3:0] units
//   min_bcd    out  [7:0] minutes, BCD 00-99
//   sec_bcd    out  [7:0] seconds, BCD 00-59
//   sec_tick   out  one-cycle pulse on each 1 s decrement in TIMER
//   half_tick  out  one-cycle pulse every HALF cycles in FLASH_ON/FLASH_OFF
//   time_up    out  sticky: countdown reached 00:00
//   flash_led  out  alarm LED drive
//   set_err    out  set_val is not valid BCD for the field being set
// ----------------------------------------------------------------------------
module egg_timer_datapath #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int CNT_W         = $clog2(TICKS_PER_SEC)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] state,
  input  logic [7:0] set_val,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       sec_tick,
  output logic       half_tick,
  output logic       time_up,
  output logic       flash_led,
  output logic       set_err
);

  localparam int HALF = TICKS_PER_SEC / 2;

  localparam logic [CNT_W-1:0] SEC_LAST  = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    ST_SET_SEC     = 3'd0,
    ST_SET_MIN     = 3'd1,
    ST_TIMER       = 3'd2,
    ST_READY       = 3'd3,
    ST_RESET       = 3'd4,
    ST_FLASH_ON    = 3'd5,
    ST_FLASH_OFF   = 3'd6,
    ST_SETTING_MIN = 3'd7
  } state_t;

  state_t cur_state;
  assign cur_state = state_t'(state);

  logic [2:0]       prev_state;
  logic [CNT_W-1:0] prescaler;

  logic [7:0]       nxt_min;
  logic [7:0]       nxt_sec;
  logic [CNT_W-1:0] nxt_prescaler;
  logic             nxt_sec_tick;
  logic             nxt_half_tick;
  logic             nxt_time_up;
  logic             nxt_flash_led;
  logic             nxt_set_err;

  logic             state_change;
  logic [15:0]      dec_val;

  assign state_change = (state != prev_state);

  // One-second BCD decrement of MM:SS; callers guarantee the input is not
  // 00:00, so the minutes borrow never underflows.
  function automatic logic [15:0] bcd_dec(input logic [7:0] m, input logic [7:0] s);
    logic [3:0] mt, mu, st, su;
    mt = m[7:4];
    mu = m[3:0];
    st = s[7:4];
    su = s[3:0];
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else if (st != 4'd0) begin
      st = st - 4'd1;
      su = 4'd9;
    end else begin
      st = 4'd5;
      su = 4'd9;
      if (mu != 4'd0) begin
        mu = mu - 4'd1;
      end else begin
        mt = mt - 4'd1;
        mu = 4'd9;
      end
    end
    return {mt, mu, st, su};
  endfunction

  assign dec_val = bcd_dec(min_bcd, sec_bcd);

  // NOTE: every signal written here gets a default first so that no path
  // through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    nxt_min       = min_bcd;
    nxt_sec       = sec_bcd;
    nxt_prescaler = '0;
    nxt_sec_tick  = 1'b0;
    nxt_half_tick = 1'b0;
    nxt_time_up   = time_up;
    nxt_flash_led = 1'b0;
    nxt_set_err   = 1'b0;

    case (cur_state)
      ST_RESET: begin
        nxt_min     = 8'h00;
        nxt_sec     = 8'h00;
        nxt_time_up = 1'b0;
      end

      ST_SET_SEC: begin
        if (set_val[7:4] <= 4'd5 && set_val[3:0] <= 4'd9) nxt_sec = set_val;
        else nxt_set_err = 1'b1;
      end

      ST_SET_MIN: begin
        if (set_val[7:4] <= 4'd9 && set_val[3:0] <= 4'd9) nxt_min = set_val;
        else nxt_set_err = 1'b1;
      end

      ST_TIMER: begin
        // A state change clears the prescaler and suppresses a coincident wrap.
        if (!state_change && prescaler != SEC_LAST) nxt_prescaler = prescaler + 1'b1;
        if (!time_up) begin
          if (min_bcd == 8'h00 && sec_bcd == 8'h00) begin
            nxt_time_up = 1'b1;
          end else if (!state_change && prescaler == SEC_LAST) begin
            {nxt_min, nxt_sec} = dec_val;
            nxt_sec_tick       = 1'b1;
            if (dec_val == 16'h0000) nxt_time_up = 1'b1;
          end
        end
      end

      ST_FLASH_ON, ST_FLASH_OFF: begin
        nxt_flash_led = (cur_state == ST_FLASH_ON);
        if (!state_change) begin
          if (prescaler == HALF_LAST) nxt_half_tick = 1'b1;
          else nxt_prescaler = prescaler + 1'b1;
        end
      end

      default: begin
        // READY and SETTING_MIN: hold the value, prescaler parked at 0.
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_bcd    <= 8'h00;
      sec_bcd    <= 8'h00;
      prescaler  <= '0;
      prev_state <= 3'd0;
      sec_tick   <= 1'b0;
      half_tick  <= 1'b0;
      time_up    <= 1'b0;
      flash_led  <= 1'b0;
      set_err    <= 1'b0;
    end else begin
      min_bcd    <= nxt_min;
      sec_bcd    <= nxt_sec;
      prescaler  <= nxt_prescaler;
      prev_state <= state;
      sec_tick   <= nxt_sec_tick;
      half_tick  <= nxt_half_tick;
      time_up    <= nxt_time_up;
      flash_led  <= nxt_flash_led;
      set_err    <= nxt_set_err;
    end
  end

endmodule

// File: tb/tb_egg_timer_datapath.sv
// ----------------------------------------------------------------------------
// tb_egg_timer_datapath
//
// Directed bench for egg_timer_datapath with TICKS_PER_SEC=10 (HALF=5).
// Inputs are driven 1 time unit after each rising edge and outputs are
// checked at the same point, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_egg_timer_datapath;

  localparam int TPS = 10;

  localparam logic [2:0] S_SET_SEC   = 3'd0;
  localparam logic [2:0] S_SET_MIN   = 3'd1;
  localparam logic [2:0] S_TIMER     = 3'd2;
  localparam logic [2:0] S_READY     = 3'd3;
  localparam logic [2:0] S_RESET     = 3'd4;
  localparam logic [2:0] S_FLASH_ON  = 3'd5;
  localparam logic [2:0] S_FLASH_OFF = 3'd6;

  logic       clk;
  logic       rst_n;
  logic [2:0] state;
  logic [7:0] set_val;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       sec_tick;
  logic       half_tick;
  logic       time_up;
  logic       flash_led;
  logic       set_err;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_count = 0;

  egg_timer_datapath #(.TICKS_PER_SEC(TPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state),
    .set_val   (set_val),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .sec_tick  (sec_tick),
    .half_tick (half_tick),
    .time_up   (time_up),
    .flash_led (flash_led),
    .set_err   (set_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count sec_tick pulses mid-cycle, independent of the directed steps.
  always @(negedge clk) if (sec_tick === 1'b1) tick_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance until the selected pulse is seen; bounded so it cannot hang.
  task automatic wait_pulse(input bit half, output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (((half ? half_tick : sec_tick) !== 1'b1) && cycles < 200);
  endtask

  task automatic load(input logic [7:0] mm, input logic [7:0] ss);
    state = S_SET_SEC; set_val = ss; step(1);
    state = S_SET_MIN; set_val = mm; step(1);
    state = S_READY;   step(1);
  endtask

  int cyc;
  int snap;

  initial begin
    rst_n   = 1'b1;
    state   = S_RESET;
    set_val = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_min", 32'(min_bcd), 32'h00);
    chk("rst_sec", 32'(sec_bcd), 32'h00);
    chk("rst_flags", 32'({sec_tick, half_tick, time_up, flash_led, set_err}), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step(2);

    // ---- switch validation --------------------------------------------------
    state = S_SET_SEC; set_val = 8'h30; step(1);
    chk("sec_load30", 32'(sec_bcd), 32'h30);
    chk("sec_err0", 32'(set_err), 32'h0);
    set_val = 8'h7A; step(1);
    chk("sec_hold_7a", 32'(sec_bcd), 32'h30);
    chk("sec_err_7a", 32'(set_err), 32'h1);
    set_val = 8'h60; step(1);
    chk("sec_hold_60", 32'(sec_bcd), 32'h30);
    chk("sec_err_60", 32'(set_err), 32'h1);
    set_val = 8'h59; step(1);
    chk("sec_load59", 32'(sec_bcd), 32'h59);
    set_val = 8'h42; step(1);
    chk("sec_load42", 32'(sec_bcd), 32'h42);
    chk("sec_err_42", 32'(set_err), 32'h0);
    state = S_SET_MIN; set_val = 8'hA0; step(1);
    chk("min_err_a0", 32'(set_err), 32'h1);
    chk("min_hold_a0", 32'(min_bcd), 32'h00);
    set_val = 8'h99; step(1);
    chk("min_load99", 32'(min_bcd), 32'h99);
    chk("min_err_99", 32'(set_err), 32'h0);
    state = S_READY; set_val = 8'hFF; step(1);
    chk("ready_no_err", 32'(set_err), 32'h0);
    chk("ready_hold", 32'({min_bcd, sec_bcd}), 32'h9942);

    // ---- full countdown from 01:05 ------------------------------------------
    load(8'h01, 8'h05);
    chk("load_0105", 32'({min_bcd, sec_bcd}), 32'h0105);
    state = S_TIMER; step(1);
    chk("timer_entry_no_tick", 32'(sec_tick), 32'h0);
    for (int k = 1; k <= 65; k++) begin
      wait_pulse(1'b0, cyc);
      chk("tick_interval", 32'(cyc), 32'd10);
      if (k == 1)  chk("val_t1",  32'({min_bcd, sec_bcd}), 32'h0104);
      if (k == 5)  chk("val_t5",  32'({min_bcd, sec_bcd}), 32'h0100);
      if (k == 6)  chk("val_t6",  32'({min_bcd, sec_bcd}), 32'h0059);
      if (k == 15) chk("val_t15", 32'({min_bcd, sec_bcd}), 32'h0050);
      if (k == 64) chk("tu_t64",  32'(time_up), 32'h0);
      if (k == 65) begin
        chk("val_t65", 32'({min_bcd, sec_bcd}), 32'h0000);
        chk("tu_t65",  32'(time_up), 32'h1);
      end
    end
    step(1);
    snap = tick_count;
    step(30);
    chk("no_tick_after_up", 32'(tick_count - snap), 32'd0);
    chk("stay_0000", 32'({min_bcd, sec_bcd, 7'd0, time_up}), 32'h0000_0001);

    // ---- RESET clears time_up, TIMER entered at 00:00 ------------------------
    state = S_RESET; step(1);
    chk("reset_tu", 32'(time_up), 32'h0);
    chk("reset_val", 32'({min_bcd, sec_bcd}), 32'h0000);
    state = S_TIMER; step(1);
    chk("zero_entry_tu", 32'(time_up), 32'h1);
    chk("zero_entry_tick", 32'(sec_tick), 32'h0);
    snap = tick_count;
    step(25);
    chk("zero_no_ticks", 32'(tick_count - snap), 32'd0);
    chk("zero_no_wrap", 32'({min_bcd, sec_bcd}), 32'h0000);

    // ---- flash phases --------------------------------------------------------
    state = S_FLASH_ON; #1;
    chk("led_lag_on", 32'(flash_led), 32'h0);
    step(1);
    chk("led_on", 32'(flash_led), 32'h1);
    chk("half_entry", 32'(half_tick), 32'h0);
    wait_pulse(1'b1, cyc);
    chk("half_on_len", 32'(cyc), 32'd5);
    chk("flash_hold", 32'({min_bcd, sec_bcd, 7'd0, time_up}), 32'h0000_0001);
    state = S_FLASH_OFF; #1;
    chk("led_lag_off", 32'(flash_led), 32'h1);
    step(1);
    chk("led_off", 32'(flash_led), 32'h0);
    chk("half_clr", 32'(half_tick), 32'h0);
    wait_pulse(1'b1, cyc);
    chk("half_off_len", 32'(cyc), 32'd5);
    wait_pulse(1'b1, cyc);
    chk("half_wrap_len", 32'(cyc), 32'd5);
    state = S_FLASH_ON; step(1);
    chk("led_on2", 32'(flash_led), 32'h1);
    state = S_READY; step(1);
    chk("led_ready", 32'(flash_led), 32'h0);
    chk("half_ready", 32'(half_tick), 32'h0);

    // ---- leave TIMER at prescaler=9 ------------------------------------------
    state = S_RESET; step(1);
    load(8'h00, 8'h10);
    state = S_TIMER; step(1);
    step(9);
    snap = tick_count;
    state = S_READY; step(1);
    chk("abort_no_tick", 32'(sec_tick), 32'h0);
    chk("abort_val", 32'({min_bcd, sec_bcd}), 32'h0010);
    step(1);
    chk("abort_count", 32'(tick_count - snap), 32'd0);
    state = S_TIMER; step(1);
    wait_pulse(1'b0, cyc);
    chk("resume_len", 32'(cyc), 32'd10);
    chk("resume_val", 32'({min_bcd, sec_bcd}), 32'h0009);

    // ---- asynchronous reset mid-count ----------------------------------------
    state = S_RESET; step(1);
    load(8'h00, 8'h30);
    state = S_TIMER; step(1);
    step(5);
    chk("pre_rst_val", 32'({min_bcd, sec_bcd}), 32'h0030);
    #2 rst_n = 1'b0;
    #1;
    chk("async_val", 32'({min_bcd, sec_bcd}), 32'h0000);
    chk("async_flags", 32'({sec_tick, half_tick, time_up, flash_led, set_err}), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step(1);
    chk("post_rst_tu", 32'(time_up), 32'h1);
    state = S_RESET; step(1);
    chk("final_reset_tu", 32'(time_up), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/egg_timer_datapath.md
Name: egg_timer_datapath

Overview:
Timekeeping datapath that responds to the 3-bit state code produced by the egg-timer control FSM. It loads minutes and seconds from the board switches, counts down in BCD at 1 Hz while the controller is in TIMER, and raises a sticky time_up flag at 00:00. During the flash states it drives the alarm LED and generates the 0.5 s pacing pulse that the controller uses to alternate between FLASH_ON and FLASH_OFF. It sits between the controller and the 7-segment/LED output logic.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per second; must be even and >= 2; HALF = TICKS_PER_SEC/2
CNT_W, $clog2(TICKS_PER_SEC), prescaler width

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous, active-low reset
state  in  3  controller state code: RESET=4, SET_SEC=0, SET_MIN=1, READY=3, TIMER=2, FLASH_OFF=6, FLASH_ON=5, SETTING_MIN=7
set_val  in  8  BCD value from switches, [7:4] tens, [3:0] units
min_bcd  out  8  minutes, BCD 00-99
sec_bcd  out  8  seconds, BCD 00-59
sec_tick  out  1  one-cycle pulse on every 1 s decrement event in TIMER
half_tick  out  1  one-cycle pulse every HALF cycles while in FLASH_ON or FLASH_OFF
time_up  out  1  sticky flag: countdown reached 00:00
flash_led  out  1  alarm LED drive
set_err  out  1  high while set_val is invalid BCD for the field currently being set

Behaviour:
- All outputs are registered. rst_n low asynchronously clears min_bcd, sec_bcd, the prescaler, prev_state, sec_tick, half_tick, time_up, flash_led and set_err to 0.
- prev_state register: the prescaler clears to 0 on the first cycle of any state change (state != prev_state).
- RESET: min_bcd=00, sec_bcd=00, time_up=0, flash_led=0, prescaler=0.
- SET_SEC: sec_bcd <= set_val each cycle if set_val[7:4]<=5 and set_val[3:0]<=9. Otherwise sec_bcd holds and set_err=1.
- SET_MIN: min_bcd <= set_val each cycle if both nibbles are <=9. Otherwise min_bcd holds and set_err=1.
- set_err is 0 in every other state.
- SETTING_MIN and READY: min_bcd and sec_bcd hold; prescaler held at 0.
- TIMER:
  - The prescaler counts 0..TICKS_PER_SEC-1. When it reaches TICKS_PER_SEC-1 it wraps to 0, and the value is decremented by 1 s with sec_tick=1 for that cycle.
  - Decrement rules, in BCD:
    - sec units 0 -> 9 with a borrow from sec tens.
    - sec 00 -> 59 with a borrow from minutes.
    - min units 0 -> 9 with a borrow from min tens.
  - When the decrement produces 00:00, time_up is set on the same edge.
  - If the value is 00:00 on entry to TIMER, time_up is set on the first TIMER edge. No decrement and no sec_tick occur, and the counter never wraps below 00:00.
  - Once time_up=1, no further decrement happens.
- FLASH_ON / FLASH_OFF:
  - min_bcd, sec_bcd and time_up hold.
  - The prescaler counts 0..HALF-1 and pulses half_tick for one cycle at HALF-1, then wraps.
  - flash_led <= 1 in FLASH_ON and 0 in FLASH_OFF, one cycle after the state is presented.
  - Because the prescaler clears on state change, each flash phase lasts exactly HALF cycles from entry.
- flash_led is 0 in every non-flash state.
- time_up clears only in RESET or when rst_n=0.
- Simultaneous events: if the state changes on the same edge that the prescaler would wrap, the clear wins and no tick is emitted.
- Reset mid-count: assertion of rst_n takes effect immediately. After release, the first posedge behaves as a state change because prev_state=0.

Test Plan:
1. TICKS_PER_SEC=10; state=SET_SEC with set_val=0x05, then SET_MIN with set_val=0x01, then TIMER -> sec_tick every 10 cycles; sequence 01:05, 01:04 ... 01:00, 00:59; after 65 ticks, time_up=1 and the value stays at 00:00.
2. SET_SEC with set_val=0x7A -> set_err=1 and sec_bcd keeps its previous value. Then set_val=0x42 -> sec_bcd=0x42 and set_err=0.
3. TIMER entered with 00:00 -> time_up=1 after the first edge; sec_tick is never asserted.
4. Alternate FLASH_ON and FLASH_OFF every half_tick -> half_tick every 5 cycles; flash_led toggles 1/0 with a 1-cycle lag.
5. Switch TIMER -> READY at prescaler=9 -> no sec_tick, and the value is unchanged. On return to TIMER, the first tick arrives 10 cycles later.
6. Assert rst_n low mid-TIMER at 00:30 -> all outputs are 0 immediately, asynchronously to clk. A RESET state after time_up -> time_up=0.
